reset_sequencer: RTL and testbench

- Consumes the system power-on reset and releases the synth's sub-system resets one at a time, in a fixed order. The order is codec/DAC interface, then MIDI receiver, then voice engine.
- Each stage must report ready, or time out, before the next stage is released.
- Sits between the reset generator and all downstream blocks.
- Also restarts the whole sequence on a soft-reset request, for example a decoded MIDI System Reset (0xFF).

---
 rtl/synth_pkg.sv | 37 +++
 rtl/sat_counter.sv | 40 ++++
 rtl/reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_reset_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared types and constants for the synth reset/control
//                fabric: sequencer state encoding, stage indices and the
//                MIDI System Reset status byte used as a soft-reset source.
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

  // Reset sequencer FSM encoding
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  // Release order of the sequenced sub-systems
  localparam int STAGE_CODEC = 0;
  localparam int STAGE_MIDI  = 1;
  localparam int STAGE_VOICE = 2;

  // Decoded MIDI System Reset status byte that requests a soft reset
  localparam logic [7:0] MIDI_SYSTEM_RESET = 8'hFF;

  // Width of the hold / timeout counters and of the stage index
  localparam int CNT_W = 16;
  localparam int IDX_W = 3;

  // Terminal compare value for a counter that must fire on its Nth edge:
  // the event is taken on the edge that sees N-1 already counted.
  function automatic logic [CNT_W-1:0] term_of(input int cycles);
    term_of = CNT_W'(cycles - 1);
  endfunction

endpackage : synth_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : 16-bit up counter with synchronous clear, count enable,
//                terminal-count compare and saturation at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import synth_pkg::*;
#(
  parameter logic [CNT_W-1:0] TERMINAL = 16'd0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic at_terminal
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  // Count enabled edges; clear has priority, and the value sticks at the top
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Saturation means the count can only pass the terminal value, never wrap
  // below it, so a >= compare stays asserted once reached.
  assign at_terminal = (count >= TERMINAL);

endmodule : sat_counter
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Releases the synth sub-system resets one at a time
//                (codec/DAC, MIDI receiver, voice engine). Each stage must
//                acknowledge with stage_ready, or time out, before the next
//                stage is released. A soft-reset pulse restarts the whole
//                sequence while keeping the sticky timeout report.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_ready,
  output logic                  timeout_flag,
  output logic [2:0]            timeout_stage
);

  localparam logic [CNT_W-1:0] HOLD_TERM    = term_of(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = term_of(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;

  logic             hold_clear;
  logic             hold_enable;
  logic             hold_done;
  logic             tmo_clear;
  logic             tmo_enable;
  logic             tmo_hit;
  logic [7:0]       ready_pad;
  logic             ready_now;
  logic             advance;

  // Zero-pad so the 3-bit stage index can address ready for any NUM_STAGES
  assign ready_pad = 8'(stage_ready);
  assign ready_now = ready_pad[idx];

  // A stage completes when it acknowledges or its wait budget runs out
  assign advance = (state == WAIT) && (ready_now || tmo_hit);

  // Hold counter runs only in HOLD; any exit or a soft request zeroes it
  assign hold_enable = (state == HOLD);
  assign hold_clear  = soft_reset_req || (state != HOLD);

  // Timeout counter restarts on every stage change so each stage gets a full budget
  assign tmo_enable = (state == WAIT);
  assign tmo_clear  = soft_reset_req || (state != WAIT) || advance;

  sat_counter #(
    .TERMINAL (HOLD_TERM)
  ) u_hold_cnt (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (hold_clear),
    .enable      (hold_enable),
    .at_terminal (hold_done)
  );

  sat_counter #(
    .TERMINAL (TIMEOUT_TERM)
  ) u_tmo_cnt (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (tmo_clear),
    .enable      (tmo_enable),
    .at_terminal (tmo_hit)
  );

  // Sequencer FSM with registered outputs: reset_n beats soft request beats ready/timeout
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= HOLD;
      idx           <= '0;
      stage_reset   <= '1;
      all_ready     <= 1'b0;
      timeout_flag  <= 1'b0;
      timeout_stage <= 3'd0;
    end else if (soft_reset_req) begin
      // Timeout report is deliberately kept so firmware can still read it
      state       <= HOLD;
      idx         <= '0;
      stage_reset <= '1;
      all_ready   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_done) begin
            stage_reset[STAGE_CODEC] <= 1'b0;
            state                    <= WAIT;
          end
        end

        WAIT: begin
          if (advance) begin
            // A timeout is only recorded when the stage never answered
            if (!ready_now) begin
              timeout_flag <= 1'b1;
              if (!timeout_flag) begin
                timeout_stage <= idx;
              end
            end
            if (idx == LAST_IDX) begin
              state     <= RUN;
              all_ready <= 1'b1;
            end else begin
              for (int k = 0; k < NUM_STAGES; k++) begin
                if (k == (int'(idx) + 1)) begin
                  stage_reset[k] <= 1'b0;
                end
              end
              idx <= idx + 1'b1;
            end
          end
        end

        RUN: begin
          // Fully released; stage_ready changes are ignored here
        end

        default: begin
          state       <= HOLD;
          idx         <= '0;
          stage_reset <= '1;
          all_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Directed self-checking bench for reset_sequencer. Expected
//                output transitions (cycle + value) are queued as stimulus is
//                driven; a monitor pops and compares on every output change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic [2:0] stage_ready = 3'b111;
  logic [2:0] stage_reset;
  logic       all_ready;
  logic       timeout_flag;
  logic [2:0] timeout_stage;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [7:0] v;
  } ev_t;

  ev_t        exp_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_v;
  logic [7:0] cur_v;
  wire  [7:0] out_v = {stage_reset, all_ready, timeout_flag, timeout_stage};

  reset_sequencer #(
    .NUM_STAGES     (3),
    .HOLD_CYCLES    (16),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .soft_reset_req (soft_reset_req),
    .stage_ready    (stage_ready),
    .stage_reset    (stage_reset),
    .all_ready      (all_ready),
    .timeout_flag   (timeout_flag),
    .timeout_stage  (timeout_stage)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of posedges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [2:0] sr, input logic ar,
                             input logic tf, input logic [2:0] ts);
    ev_t e;
    e.c = c;
    e.v = {sr, ar, tf, ts};
    return e;
  endfunction

  // Scoreboard monitor: every output change must match the next queued event
  always @(negedge clk) begin
    if (mon_en) begin
      cur_v = out_v;
      if (cur_v !== prev_v) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_change: observed=%0h previous=%0h (cycle %0d)", cur_v, prev_v, cyc);
        end
        if (exp_q.size() != 0) begin
          ev_t e;
          e = exp_q.pop_front();
          check("event_value", 32'(cur_v), 32'(e.v));
          check("event_cycle", 32'(cyc), 32'(e.c));
        end
      end
      prev_v = cur_v;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_stage_reset", 32'(stage_reset), 32'h7);
    check("rst_all_ready", 32'(all_ready), 32'd0);
    check("rst_timeout_flag", 32'(timeout_flag), 32'd0);
    check("rst_timeout_stage", 32'(timeout_stage), 32'd0);
  endtask

  // Hold reset_n low for ncyc edges; base = edge count just before cycle 1
  task automatic reset_pulse(input int ncyc, input bit push_ev, output int base);
    int r;
    @(negedge clk);
    reset_n = 1'b0;
    r = cyc + 1;
    if (push_ev) exp_q.push_back(mk(r, 3'b111, 1'b0, 1'b0, 3'd0));
    repeat (ncyc) @(negedge clk);
    check_reset_state();
    reset_n = 1'b1;
    base = cyc;
  endtask

  task automatic soft_pulse(output int s);
    @(negedge clk);
    soft_reset_req = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    soft_reset_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int s;
    int s2;
    int t;

    // 1) Power-on with all stages ready immediately
    stage_ready = 3'b111;
    reset_pulse(3, 1'b0, b);
    prev_v = out_v;
    mon_en = 1'b1;
    exp_q.push_back(mk(b + 16, 3'b110, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(b + 17, 3'b100, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(b + 18, 3'b000, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(b + 19, 3'b000, 1'b1, 1'b0, 3'd0));
    drain(60);

    // 2) Delayed acknowledgements at cycles 40, 100, 105
    stage_ready = 3'b000;
    reset_pulse(2, 1'b1, b);
    exp_q.push_back(mk(b + 16, 3'b110, 1'b0, 1'b0, 3'd0));
    wait_until(b + 40);
    stage_ready = 3'b001;
    exp_q.push_back(mk(b + 41, 3'b100, 1'b0, 1'b0, 3'd0));
    wait_until(b + 100);
    stage_ready = 3'b011;
    exp_q.push_back(mk(b + 101, 3'b000, 1'b0, 1'b0, 3'd0));
    wait_until(b + 105);
    stage_ready = 3'b111;
    exp_q.push_back(mk(b + 106, 3'b000, 1'b1, 1'b0, 3'd0));
    drain(40);

    // 3) Stage 1 never answers: 1024-cycle timeout
    stage_ready = 3'b101;
    reset_pulse(2, 1'b1, b);
    exp_q.push_back(mk(b + 16, 3'b110, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(b + 17, 3'b100, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(b + 17 + 1024, 3'b000, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(b + 18 + 1024, 3'b000, 1'b1, 1'b1, 3'd1));
    drain(1200);

    // 4) Soft reset in RUN: same timing, timeout report preserved
    stage_ready = 3'b111;
    soft_pulse(s);
    exp_q.push_back(mk(s, 3'b111, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s + 16, 3'b110, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s + 17, 3'b100, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s + 18, 3'b000, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s + 19, 3'b000, 1'b1, 1'b1, 3'd1));
    drain(60);

    // 5) Second soft pulse mid-HOLD restarts the hold count
    soft_pulse(s);
    exp_q.push_back(mk(s, 3'b111, 1'b0, 1'b1, 3'd1));
    wait_until(s + 8);
    soft_pulse(s2);
    exp_q.push_back(mk(s2 + 16, 3'b110, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s2 + 17, 3'b100, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s2 + 18, 3'b000, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s2 + 19, 3'b000, 1'b1, 1'b1, 3'd1));
    drain(80);

    // 6) Soft request and ready[0] on the same edge in WAIT(0): soft wins
    stage_ready = 3'b000;
    soft_pulse(s);
    exp_q.push_back(mk(s, 3'b111, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(s + 16, 3'b110, 1'b0, 1'b1, 3'd1));
    wait_until(s + 20);
    soft_reset_req = 1'b1;
    stage_ready    = 3'b001;
    t = cyc + 1;
    exp_q.push_back(mk(t, 3'b111, 1'b0, 1'b1, 3'd1));
    @(negedge clk);
    soft_reset_req = 1'b0;
    exp_q.push_back(mk(t + 16, 3'b110, 1'b0, 1'b1, 3'd1));
    exp_q.push_back(mk(t + 17, 3'b100, 1'b0, 1'b1, 3'd1));
    wait_until(t + 30);

    // 7) One-cycle reset_n mid-WAIT(1) clears everything, including the flag
    reset_pulse(1, 1'b1, b);
    exp_q.push_back(mk(b + 16, 3'b110, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(b + 17, 3'b100, 1'b0, 1'b0, 3'd0));
    drain(60);
    check("final_timeout_flag", 32'(timeout_flag), 32'd0);
    check("final_all_ready", 32'(all_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reset_sequencer
`default_nettype wire
